audio_channel: RTL and testbench

AUDIO_CHANNEL -- requirements
Module: audio_channel

---
 rtl/audio_channel.sv | 146 ++++++++++++++
 tb/tb_audio_channel.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_channel.sv
// Audio DMA channel: descriptor-driven word fetch into a sample FIFO, popped by a playback strobe.
// Build option AUDIO_CHANNEL_UNDERRUN_HOLD_EN: underrun holds the last sample instead of outputting silence.
module audio_channel #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_dma_setup_request,
  input  logic        i_dma_setup_append_or_replace,
  input  logic [23:0] i_dma_setup_count,
  input  logic [31:0] i_dma_setup_address,
  output logic        o_dma_request,
  output logic [31:0] o_dma_address,
  input  logic        i_dma_ready,
  input  logic [31:0] i_dma_rdata,
  output logic        o_busy,
  input  logic        i_output_sample_clock,
  output logic [15:0] o_output_sample_left,
  output logic [15:0] o_output_sample_right
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [31:0]   mem [FIFO_DEPTH];
  logic [31:0]   head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_count;

  logic [31:0] act_addr, pend_addr, nxt_addr, nxt_pend_addr;
  logic [23:0] act_count, pend_count, nxt_count, nxt_pend_count;
  logic        pend_valid, nxt_pend_valid;
  logic        dma_req, nxt_req;
  logic        push, pop, flush, replace, append;

  assign replace       = i_dma_setup_request && !i_dma_setup_append_or_replace;
  assign append        = i_dma_setup_request && i_dma_setup_append_or_replace &&
                         (i_dma_setup_count != '0);
  assign pop           = i_output_sample_clock && (fifo_count != '0);
  assign head          = mem[rd_ptr];
  assign o_dma_request = dma_req;
  assign o_dma_address = act_addr;

  always_comb begin
    nxt_addr       = act_addr;
    nxt_count      = act_count;
    nxt_pend_addr  = pend_addr;
    nxt_pend_count = pend_count;
    nxt_pend_valid = pend_valid;
    nxt_req        = dma_req;
    push           = 1'b0;
    flush          = 1'b0;
    if (replace) begin
      nxt_addr       = i_dma_setup_address;
      nxt_count      = i_dma_setup_count;
      nxt_pend_valid = 1'b0;
      nxt_req        = 1'b0;
      flush          = 1'b1;
    end else begin
      if (dma_req) begin
        if (i_dma_ready) begin
          push      = 1'b1;
          nxt_addr  = act_addr + 32'd4;
          nxt_count = act_count - 24'd1;
          nxt_req   = 1'b0;
        end
      end else begin
        nxt_req = (act_count != '0) && (fifo_count < (AW+1)'(FIFO_DEPTH));
      end
      // Appends always land in the pending slot; an idle (or just-drained)
      // channel promotes it straight away, which also covers append-while-idle.
      if (append) begin
        nxt_pend_addr  = i_dma_setup_address;
        nxt_pend_count = i_dma_setup_count;
        nxt_pend_valid = 1'b1;
      end
      if (nxt_count == '0 && nxt_pend_valid) begin
        nxt_addr       = nxt_pend_addr;
        nxt_count      = nxt_pend_count;
        nxt_pend_valid = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      act_addr   <= '0;
      act_count  <= '0;
      pend_addr  <= '0;
      pend_count <= '0;
      pend_valid <= 1'b0;
      dma_req    <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      act_addr   <= nxt_addr;
      act_count  <= nxt_count;
      pend_addr  <= nxt_pend_addr;
      pend_count <= nxt_pend_count;
      pend_valid <= nxt_pend_valid;
      dma_req    <= nxt_req;
      o_busy     <= (nxt_count != '0) || nxt_pend_valid;
    end
  end

  always_ff @(posedge i_clock) begin
    if (push) mem[wr_ptr] <= i_dma_rdata;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_output_sample_left  <= '0;
      o_output_sample_right <= '0;
    end else if (pop) begin
      o_output_sample_left  <= head[15:0];
      o_output_sample_right <= head[31:16];
    end else if (i_output_sample_clock) begin
`ifdef AUDIO_CHANNEL_UNDERRUN_HOLD_EN
      o_output_sample_left  <= o_output_sample_left;
      o_output_sample_right <= o_output_sample_right;
`else
      o_output_sample_left  <= '0;
      o_output_sample_right <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_audio_channel.sv
// Directed self-checking bench for audio_channel: descriptors, DMA handshake, FIFO, playback, reset.
module tb_audio_channel;

  logic        i_clock;
  logic        i_reset;
  logic        i_dma_setup_request;
  logic        i_dma_setup_append_or_replace;
  logic [23:0] i_dma_setup_count;
  logic [31:0] i_dma_setup_address;
  logic        o_dma_request;
  logic [31:0] o_dma_address;
  logic        i_dma_ready;
  logic [31:0] i_dma_rdata;
  logic        o_busy;
  logic        i_output_sample_clock;
  logic [15:0] o_output_sample_left;
  logic [15:0] o_output_sample_right;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] last_w = '0;

  audio_channel #(.FIFO_DEPTH(16)) dut (
    .i_clock                       (i_clock),
    .i_reset                       (i_reset),
    .i_dma_setup_request           (i_dma_setup_request),
    .i_dma_setup_append_or_replace (i_dma_setup_append_or_replace),
    .i_dma_setup_count             (i_dma_setup_count),
    .i_dma_setup_address           (i_dma_setup_address),
    .o_dma_request                 (o_dma_request),
    .o_dma_address                 (o_dma_address),
    .i_dma_ready                   (i_dma_ready),
    .i_dma_rdata                   (i_dma_rdata),
    .o_busy                        (o_busy),
    .i_output_sample_clock         (i_output_sample_clock),
    .o_output_sample_left          (o_output_sample_left),
    .o_output_sample_right         (o_output_sample_right)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic setup(input logic app, input logic [31:0] addr, input logic [23:0] cnt);
    i_dma_setup_request           = 1'b1;
    i_dma_setup_append_or_replace = app;
    i_dma_setup_address           = addr;
    i_dma_setup_count             = cnt;
    tick();
    i_dma_setup_request = 1'b0;
  endtask

  task automatic wait_req(input logic [31:0] exp_addr, input string name);
    int n = 0;
    while (o_dma_request !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    compared++;
    if (o_dma_request !== 1'b1) begin
      mismatched++;
      $display("FAIL %s request: got %b expected 1 (timeout)", name, o_dma_request);
    end
    compared++;
    if (o_dma_address !== exp_addr) begin
      mismatched++;
      $display("FAIL %s address: got %h expected %h", name, o_dma_address, exp_addr);
    end
  endtask

  task automatic serve(input logic [31:0] exp_addr, input logic [31:0] data,
                       input logic exp_busy, input int hold, input string name);
    wait_req(exp_addr, name);
    if (hold != 0) begin
      repeat (hold) @(posedge i_clock);
      #1;
      compared++;
      if (o_dma_request !== 1'b1 || o_dma_address !== exp_addr) begin
        mismatched++;
        $display("FAIL %s hold: got req=%b addr=%h expected req=1 addr=%h",
                 name, o_dma_request, o_dma_address, exp_addr);
      end
    end
    i_dma_ready = 1'b1;
    i_dma_rdata = data;
    tick();
    i_dma_ready = 1'b0;
    compared++;
    if (o_dma_request !== 1'b0) begin
      mismatched++;
      $display("FAIL %s drop: got req=%b expected 0", name, o_dma_request);
    end
    compared++;
    if (o_busy !== exp_busy) begin
      mismatched++;
      $display("FAIL %s busy: got %b expected %b", name, o_busy, exp_busy);
    end
  endtask

  task automatic strobe(input logic [31:0] w, input string name);
    i_output_sample_clock = 1'b1;
    tick();
    i_output_sample_clock = 1'b0;
    last_w = w;
    compared++;
    if (o_output_sample_left !== w[15:0] || o_output_sample_right !== w[31:16]) begin
      mismatched++;
      $display("FAIL %s sample: got L=%h R=%h expected L=%h R=%h", name,
               o_output_sample_left, o_output_sample_right, w[15:0], w[31:16]);
    end
  endtask

  task automatic strobe_underrun(input string name);
`ifdef AUDIO_CHANNEL_UNDERRUN_HOLD_EN
    strobe(last_w, name);
`else
    strobe(32'h0, name);
`endif
  endtask

  task automatic check_idle(input string name);
    repeat (3) tick();
    compared++;
    if (o_dma_request !== 1'b0 || o_busy !== 1'b0) begin
      mismatched++;
      $display("FAIL %s idle: got req=%b busy=%b expected req=0 busy=0", name, o_dma_request, o_busy);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (2) tick();
    compared++;
    if (o_dma_request !== 1'b0 || o_busy !== 1'b0 || o_dma_address !== 32'h0 ||
        o_output_sample_left !== 16'h0 || o_output_sample_right !== 16'h0) begin
      mismatched++;
      $display("FAIL reset: got req=%b busy=%b addr=%h L=%h R=%h expected all 0",
               o_dma_request, o_busy, o_dma_address, o_output_sample_left, o_output_sample_right);
    end
    i_reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    setup(1'b0, 32'h1000, 24'd3);
    compared++;
    if (o_busy !== 1'b1) begin
      mismatched++;
      $display("FAIL basic busy_start: got %b expected 1", o_busy);
    end
    serve(32'h1000, 32'h0002_0001, 1'b1, 3, "basic0");
    serve(32'h1004, 32'h0004_0003, 1'b1, 0, "basic1");
    serve(32'h1008, 32'h0006_0005, 1'b0, 0, "basic2");
    check_idle("basic_end");
    strobe(32'h0002_0001, "play0");
    strobe(32'h0004_0003, "play1");
    strobe(32'h0006_0005, "play2");
    strobe_underrun("underrun0");
  endtask

  task automatic test_append();
    setup(1'b0, 32'h1000, 24'd2);
    setup(1'b1, 32'h2000, 24'd2);
    serve(32'h1000, 32'h1111_0101, 1'b1, 0, "append0");
    serve(32'h1004, 32'h2222_0202, 1'b1, 0, "append1");
    serve(32'h2000, 32'h3333_0303, 1'b1, 0, "append2");
    serve(32'h2004, 32'h4444_0404, 1'b0, 0, "append3");
    strobe(32'h1111_0101, "append_play0");
    strobe(32'h2222_0202, "append_play1");
    strobe(32'h3333_0303, "append_play2");
    strobe(32'h4444_0404, "append_play3");
  endtask

  task automatic test_replace();
    setup(1'b0, 32'h1000, 24'd2);
    serve(32'h1000, 32'hBEEF_0A0A, 1'b1, 0, "repl0");
    wait_req(32'h1004, "repl_pending");
    // replace and completion on the same edge: replace wins, data dropped
    i_dma_setup_request           = 1'b1;
    i_dma_setup_append_or_replace = 1'b0;
    i_dma_setup_address           = 32'h3000;
    i_dma_setup_count             = 24'd1;
    i_dma_ready                   = 1'b1;
    i_dma_rdata                   = 32'hDEAD_DEAD;
    tick();
    i_dma_setup_request = 1'b0;
    i_dma_rdata         = 32'hBAD0_BAD0;
    compared++;
    if (o_dma_request !== 1'b0) begin
      mismatched++;
      $display("FAIL repl_drop: got req=%b expected 0", o_dma_request);
    end
    tick();
    i_dma_ready = 1'b0;
    serve(32'h3000, 32'h0033_0003, 1'b0, 0, "repl1");
    strobe(32'h0033_0003, "repl_play");
    strobe_underrun("repl_underrun");
  endtask

  task automatic test_zero_count();
    setup(1'b1, 32'h7000, 24'd0);
    check_idle("zero_append");
    setup(1'b0, 32'h4000, 24'd5);
    serve(32'h4000, 32'h5555_AAAA, 1'b1, 0, "zero_pre");
    setup(1'b0, 32'h8000, 24'd0);
    compared++;
    if (o_busy !== 1'b0) begin
      mismatched++;
      $display("FAIL zero_replace busy: got %b expected 0", o_busy);
    end
    check_idle("zero_replace");
    strobe_underrun("zero_flushed");
  endtask

  task automatic test_wrap();
    setup(1'b0, 32'hFFFF_FFFC, 24'd2);
    serve(32'hFFFF_FFFC, 32'h7FFF_8000, 1'b1, 0, "wrap0");
    serve(32'h0000_0000, 32'h1234_5678, 1'b0, 0, "wrap1");
    strobe(32'h7FFF_8000, "wrap_play0");
    strobe(32'h1234_5678, "wrap_play1");
  endtask

  task automatic test_reset_mid();
    setup(1'b0, 32'h5000, 24'd2);
    wait_req(32'h5000, "rst_mid_req");
    i_reset = 1'b1;
    #1;
    compared++;
    if (o_dma_request !== 1'b0 || o_busy !== 1'b0 || o_dma_address !== 32'h0 ||
        o_output_sample_left !== 16'h0 || o_output_sample_right !== 16'h0) begin
      mismatched++;
      $display("FAIL rst_mid: got req=%b busy=%b addr=%h L=%h R=%h expected all 0",
               o_dma_request, o_busy, o_dma_address, o_output_sample_left, o_output_sample_right);
    end
    tick();
    i_reset     = 1'b0;
    i_dma_ready = 1'b1;
    i_dma_rdata = 32'hCAFE_F00D;
    tick();
    i_dma_ready = 1'b0;
    last_w = '0;
    check_idle("rst_mid_after");
    strobe_underrun("rst_mid_empty");
  endtask

  task automatic test_full();
    logic [31:0] w;
    setup(1'b0, 32'h0000_0100, 24'd17);
    for (int i = 0; i < 16; i++) begin
      w = {16'h8000 | 16'(i), 16'(i)};
      serve(32'h100 + 32'(4 * i), w, 1'b1, 0, "full_fill");
    end
    repeat (4) tick();
    compared++;
    if (o_dma_request !== 1'b0) begin
      mismatched++;
      $display("FAIL full_stall: got req=%b expected 0", o_dma_request);
    end
    strobe(32'h8000_0000, "full_play0");
    serve(32'h0000_0140, 32'h8010_0010, 1'b0, 0, "full_last");
    for (int i = 1; i < 17; i++) begin
      w = {16'h8000 | 16'(i), 16'(i)};
      strobe(w, "full_drain");
    end
    strobe_underrun("full_underrun");
  endtask

  initial begin
    i_reset                       = 1'b1;
    i_dma_setup_request           = 1'b0;
    i_dma_setup_append_or_replace = 1'b0;
    i_dma_setup_count             = '0;
    i_dma_setup_address           = '0;
    i_dma_ready                   = 1'b0;
    i_dma_rdata                   = '0;
    i_output_sample_clock         = 1'b0;
    test_reset();
    test_basic();
    test_append();
    test_replace();
    test_zero_count();
    test_full();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
